// File: rtl/color_period_classifier.sv
// color_period_classifier
// Drives the TCS3200 filter-select pins, measures the sensor output period on
// red, green and blue in turn (averaged over 2^AVG_LOG2 periods) and classifies
// the nib as red, green, blue or yellow.
//
// Ports:
//   clk           single clock, rising edge
//   reset         asynchronous, active-high
//   freq_in       sensor square wave, asynchronous to clk
//   start         request a classification (sampled only when idle)
//   color_select  {S3,S2}: red 00, green 11, blue 10, clear/idle 01
//   busy          classification in progress
//   done          one-cycle strobe, color valid
//   color         red 00, green 01, blue 10, yellow 11
//   timeout       at least one channel timed out in the last run
//   red_period, green_period, blue_period  scaled, saturated average periods

module color_period_classifier #(
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned SHIFT          = 3,
  parameter int unsigned OUT_W          = 8,
  parameter int unsigned SETTLE_CYCLES  = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freq_in,
  input  logic             start,
  output logic [1:0]       color_select,
  output logic             busy,
  output logic             done,
  output logic [1:0]       color,
  output logic             timeout,
  output logic [OUT_W-1:0] red_period,
  output logic [OUT_W-1:0] green_period,
  output logic [OUT_W-1:0] blue_period
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned EW = AVG_LOG2 + 1;
  localparam logic [EW-1:0]    LastEdge = EW'((1 << AVG_LOG2) - 1);
  localparam logic [SW-1:0]    SettleLast = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] OutMax = CNT_W'({OUT_W{1'b1}});

  typedef enum logic [2:0] {
    StIdle, StSettle, StArm, StMeasure, StStore, StDecide
  } state_e;

  // Encodings double as the {S3,S2} filter-select value.
  typedef enum logic [1:0] {
    ChRed   = 2'b00,
    ChGreen = 2'b11,
    ChBlue  = 2'b10
  } chan_e;

  state_e           state_q, state_d;
  chan_e            chan_q, chan_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [EW-1:0]    ecnt_q, ecnt_d;
  logic             chan_to_q, chan_to_d;
  logic             timeout_q, timeout_d;
  logic [OUT_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [1:0]       color_q, color_d;
  logic             done_q, done_d;

  logic sync1_q, sync2_q, sync3_q;
  logic freq_edge;

  logic [CNT_W-1:0] scaled;
  logic [OUT_W-1:0] chan_val;
  logic [1:0]       color_pick;

  // Two-flop synchroniser followed by a rising-edge detector.
  assign freq_edge = sync2_q & ~sync3_q;

  // Average over 2^AVG_LOG2 periods, drop SHIFT LSBs, saturate to OUT_W bits.
  // A timed-out channel reports all-ones.
  always_comb begin
    scaled = acc_q >> (AVG_LOG2 + SHIFT);
    if (chan_to_q || (scaled > OutMax)) begin
      chan_val = '1;
    end else begin
      chan_val = scaled[OUT_W-1:0];
    end
  end

  // Yellow when blue strictly dominates; otherwise the minimum channel,
  // ties resolved red, then green, then blue.
  always_comb begin
    if ((blue_q > red_q) && (blue_q > green_q)) begin
      color_pick = 2'b11;
    end else if ((red_q <= green_q) && (red_q <= blue_q)) begin
      color_pick = 2'b00;
    end else if (green_q <= blue_q) begin
      color_pick = 2'b01;
    end else begin
      color_pick = 2'b10;
    end
  end

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    settle_d  = settle_q;
    timer_d   = timer_q;
    acc_d     = acc_q;
    ecnt_d    = ecnt_q;
    chan_to_d = chan_to_q;
    timeout_d = timeout_q;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    color_d   = color_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSettle;
          chan_d    = ChRed;
          settle_d  = '0;
          timeout_d = 1'b0;
        end
      end

      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d   = StArm;
          timer_d   = '0;
          chan_to_d = 1'b0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      StArm: begin
        timer_d = timer_q + TW'(1);
        if (freq_edge) begin
          state_d = StMeasure;
          acc_d   = '0;
          ecnt_d  = '0;
        end else if (timer_q == TimeoutLast) begin
          chan_to_d = 1'b1;
          state_d   = StStore;
        end
      end

      StMeasure: begin
        timer_d = timer_q + TW'(1);
        // Counting includes the terminating edge cycle, so the captured value
        // is the exact distance between first and last edge.
        acc_d = (acc_q == '1) ? acc_q : acc_q + CNT_W'(1);
        if (freq_edge) begin
          ecnt_d = ecnt_q + EW'(1);
          if (ecnt_q == LastEdge) begin
            state_d = StStore;
          end
        end else if (timer_q == TimeoutLast) begin
          chan_to_d = 1'b1;
          state_d   = StStore;
        end
      end

      StStore: begin
        timeout_d = timeout_q | chan_to_q;
        settle_d  = '0;
        unique case (chan_q)
          ChRed: begin
            red_d   = chan_val;
            chan_d  = ChGreen;
            state_d = StSettle;
          end
          ChGreen: begin
            green_d = chan_val;
            chan_d  = ChBlue;
            state_d = StSettle;
          end
          default: begin
            blue_d  = chan_val;
            state_d = StDecide;
          end
        endcase
      end

      StDecide: begin
        color_d = color_pick;
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      state_q   <= StIdle;
      chan_q    <= ChRed;
      settle_q  <= '0;
      timer_q   <= '0;
      acc_q     <= '0;
      ecnt_q    <= '0;
      chan_to_q <= 1'b0;
      timeout_q <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      color_q   <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      sync1_q   <= freq_in;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      state_q   <= state_d;
      chan_q    <= chan_d;
      settle_q  <= settle_d;
      timer_q   <= timer_d;
      acc_q     <= acc_d;
      ecnt_q    <= ecnt_d;
      chan_to_q <= chan_to_d;
      timeout_q <= timeout_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      color_q   <= color_d;
      done_q    <= done_d;
    end
  end

  // done is registered out of DECIDE, so it coincides with IDLE: busy low,
  // filter back on clear.
  always_comb begin
    busy         = (state_q != StIdle);
    color_select = 2'b01;
    if ((state_q == StSettle) || (state_q == StArm) ||
        (state_q == StMeasure) || (state_q == StStore)) begin
      color_select = chan_q;
    end
  end

  assign done         = done_q;
  assign color        = color_q;
  assign timeout      = timeout_q;
  assign red_period   = red_q;
  assign green_period = green_q;
  assign blue_period  = blue_q;

endmodule

// File: tb/tb_color_period_classifier.sv
// Directed bench for color_period_classifier. Two instances: dut_a with the
// default timeout, dut_b with a 4096-cycle timeout for the dark-channel case.
// Each instance gets a square wave whose period follows its own filter select.

module tb_color_period_classifier;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       freq_a, freq_b;
  logic       start_a, start_b;
  logic [1:0] sel_a, sel_b, color_a, color_b;
  logic       busy_a, busy_b, done_a, done_b, to_a, to_b;
  logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;

  int pa_r = 80, pa_g = 80, pa_b = 80;
  int pb_r = 80, pb_g = 80, pb_b = 80;
  int n_checks = 0;
  int n_errors = 0;
  int n_done_a = 0;
  int n_done_b = 0;

  always #5 clk = ~clk;

  color_period_classifier dut_a (
    .clk          (clk),
    .reset        (rst_a),
    .freq_in      (freq_a),
    .start        (start_a),
    .color_select (sel_a),
    .busy         (busy_a),
    .done         (done_a),
    .color        (color_a),
    .timeout      (to_a),
    .red_period   (red_a),
    .green_period (green_a),
    .blue_period  (blue_a)
  );

  color_period_classifier #(
    .TIMEOUT_CYCLES (4096)
  ) dut_b (
    .clk          (clk),
    .reset        (rst_b),
    .freq_in      (freq_b),
    .start        (start_b),
    .color_select (sel_b),
    .busy         (busy_b),
    .done         (done_b),
    .color        (color_b),
    .timeout      (to_b),
    .red_period   (red_b),
    .green_period (green_b),
    .blue_period  (blue_b)
  );

  always @(posedge clk) begin
    if (done_a) n_done_a <= n_done_a + 1;
    if (done_b) n_done_b <= n_done_b + 1;
  end

  function automatic int pick(input logic [1:0] sel, input int r, input int g, input int b);
    case (sel)
      2'b11:   return g;
      2'b10:   return b;
      default: return r;
    endcase
  endfunction

  // Period 0 holds the line low.
  initial begin
    int p;
    freq_a = 1'b0;
    forever begin
      @(negedge clk);
      p = pick(sel_a, pa_r, pa_g, pa_b);
      if (p != 0) begin
        freq_a = 1'b1;
        repeat (p / 2 - 1) @(negedge clk);
        @(negedge clk);
        freq_a = 1'b0;
        repeat (p - p / 2 - 1) @(negedge clk);
      end
    end
  end

  initial begin
    int p;
    freq_b = 1'b0;
    forever begin
      @(negedge clk);
      p = pick(sel_b, pb_r, pb_g, pb_b);
      if (p != 0) begin
        freq_b = 1'b1;
        repeat (p / 2 - 1) @(negedge clk);
        @(negedge clk);
        freq_b = 1'b0;
        repeat (p - p / 2 - 1) @(negedge clk);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle; check the accept-cycle outputs.
  task automatic kick(input bit which, input string tag);
    @(negedge clk);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    if (which) begin
      start_b = 1'b0;
      check({tag, "_busy_on"}, 32'(busy_b), 32'd1);
      check({tag, "_sel_red"}, 32'(sel_b), 32'd0);
      check({tag, "_to_clr"}, 32'(to_b), 32'd0);
    end else begin
      start_a = 1'b0;
      check({tag, "_busy_on"}, 32'(busy_a), 32'd1);
      check({tag, "_sel_red"}, 32'(sel_a), 32'd0);
    end
  endtask

  // Wait for done (bounded); on arrival check the done-cycle handshake.
  task automatic wait_done(input bit which, input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (which ? done_b : done_a) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_busy_off"}, 32'(which ? busy_b : busy_a), 32'd0);
      check({tag, "_sel_idle"}, 32'(which ? sel_b : sel_a), 32'd1);
    end
  endtask

  task automatic expect_a(input string tag, input int r, input int g, input int b,
                          input int col, input int to);
    check({tag, "_red"}, 32'(red_a), 32'(r));
    check({tag, "_green"}, 32'(green_a), 32'(g));
    check({tag, "_blue"}, 32'(blue_a), 32'(b));
    check({tag, "_color"}, 32'(color_a), 32'(col));
    check({tag, "_timeout"}, 32'(to_a), 32'(to));
    @(posedge clk);
    #1;
    check({tag, "_done_1cyc"}, 32'(done_a), 32'd0);
    check({tag, "_color_hold"}, 32'(color_a), 32'(col));
  endtask

  initial begin
    int d0;
    bit found;
    rst_a = 1'b1;
    rst_b = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", 32'(sel_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_color", 32'(color_a), 32'd0);
    check("rst_timeout", 32'(to_a), 32'd0);
    check("rst_red", 32'(red_a), 32'd0);
    check("rst_blue_b", 32'(blue_b), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // 80/160/240 -> 10/20/30, blue dominates -> yellow
    pa_r = 80; pa_g = 160; pa_b = 240;
    kick(1'b0, "t1");
    wait_done(1'b0, 8000, "t1");
    expect_a("t1", 10, 20, 30, 3, 0);

    // 240/80/160 -> 30/10/20 -> green
    pa_r = 240; pa_g = 80; pa_b = 160;
    kick(1'b0, "t2");
    wait_done(1'b0, 8000, "t2");
    expect_a("t2", 30, 10, 20, 1, 0);

    // All equal -> red by tie priority
    pa_r = 80; pa_g = 80; pa_b = 80;
    kick(1'b0, "t3");
    wait_done(1'b0, 8000, "t3");
    expect_a("t3", 10, 10, 10, 0, 0);

    // Green dark on dut_b -> green 255, timeout set, red wins (10 < 30 < 255)
    pb_r = 80; pb_g = 0; pb_b = 240;
    kick(1'b1, "t4");
    wait_done(1'b1, 12000, "t4");
    check("t4_red", 32'(red_b), 32'd10);
    check("t4_green", 32'(green_b), 32'd255);
    check("t4_blue", 32'(blue_b), 32'd30);
    check("t4_timeout", 32'(to_b), 32'd1);
    check("t4_color", 32'(color_b), 32'd0);
    // Next accepted start clears timeout (checked inside kick)
    pb_g = 160;
    kick(1'b1, "t4b");
    wait_done(1'b1, 8000, "t4b");
    check("t4b_timeout", 32'(to_b), 32'd0);
    check("t4b_color", 32'(color_b), 32'd3);

    // Red period 4000 -> 500 saturates to 255; green 20 is minimum
    pa_r = 4000; pa_g = 160; pa_b = 240;
    d0 = n_done_a;
    kick(1'b0, "t5");
    repeat (5000) @(posedge clk);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 40000, "t5");
    expect_a("t5", 255, 20, 30, 1, 0);
    repeat (600) @(posedge clk);
    #1;
    check("t5_no_requeue", 32'(busy_a), 32'd0);
    check("t5_one_done", 32'(n_done_a - d0), 32'd1);

    // Reset during blue MEASURE
    pa_r = 80; pa_g = 160; pa_b = 240;
    kick(1'b0, "t6");
    found = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk);
      #1;
      if (sel_a == 2'b10) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reach_blue", 32'(found), 32'd1);
    repeat (700) @(posedge clk);
    d0 = n_done_a;
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    check("t6_busy", 32'(busy_a), 32'd0);
    check("t6_sel", 32'(sel_a), 32'd1);
    check("t6_red", 32'(red_a), 32'd0);
    check("t6_green", 32'(green_a), 32'd0);
    check("t6_blue", 32'(blue_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (1500) @(posedge clk);
    #1;
    check("t6_no_done", 32'(n_done_a - d0), 32'd0);
    kick(1'b0, "t6b");
    wait_done(1'b0, 8000, "t6b");
    expect_a("t6b", 10, 20, 30, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/color_period_classifier.md
# color_period_classifier

Parametrised successor to the single-shot colour detector. Drives the TCS3200 filter-select pins, measures the sensor's output period on red, green and blue in turn, and classifies the nib as red, green, blue or yellow. Sits between the sensor-bar selector (start/done handshake) and the cartridge RAM writer (colour + done strobe). New over the current detector: per-channel settle delay, multi-period averaging, per-channel timeout, output saturation, defined tie-breaking and a busy/done handshake.

## Interface
- `AVG_LOG2`, default 2: log2 of sensor periods accumulated per channel; legal range 0..3.
- `CNT_W`, default 24: width of the period accumulator.
- `SHIFT`, default 3: LSBs dropped from the averaged period before output.
- `OUT_W`, default 8: width of the per-channel period outputs.
- `SETTLE_CYCLES`, default 256: clk cycles waited after each filter change.
- `TIMEOUT_CYCLES`, default 2^20: per-channel limit on clk cycles spent in ARM plus MEASURE.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `freq_in` in 1: sensor square wave; asynchronous to `clk`.
- `start` in 1: request a classification; sampled only in IDLE.
- `color_select` out 2: {S3,S2} filter select. Red 00, green 11, blue 10, clear/idle 01.
- `busy` out 1: high while a classification is in progress.
- `done` out 1: one-cycle strobe when `color` is valid.
- `color` out 2: result. Red 00, green 01, blue 10, yellow 11.
- `timeout` out 1: at least one channel timed out in the last run.
- `red_period`, `green_period`, `blue_period` out OUT_W: scaled average periods.

## Operation
- `freq_in` passes through a 2-flop synchroniser and a rising-edge detector. The result is `edge`, a one-cycle pulse.
- States and transitions:
  - IDLE: if `start`, go to SETTLE with channel = red. While in IDLE, `color_select` = 01.
  - SETTLE: count SETTLE_CYCLES cycles, then go to ARM.
  - ARM: on `edge`, go to MEASURE. Clear the accumulator and the edge counter.
  - MEASURE: increment the accumulator every cycle and count `edge` pulses. When the 2^AVG_LOG2-th edge arrives, go to STORE.
  - STORE: write the result to the channel register. If the channel was red, go to SETTLE for green; if green, go to SETTLE for blue; if blue, go to DECIDE.
  - DECIDE: register `color`, pulse `done`, drop `busy`, return to IDLE.
- `color_select` follows the current channel in SETTLE, ARM, MEASURE and STORE.
- Captured accumulator value = exact number of clk cycles between the first and the last counted `edge` pulse. The accumulator saturates at 2^CNT_W-1 and does not wrap.
- Channel value = (acc >> AVG_LOG2) >> SHIFT. If the value exceeds 2^OUT_W-1, output 2^OUT_W-1.
- Timeout: if ARM plus MEASURE reaches TIMEOUT_CYCLES for a channel, the channel value is all-ones, `timeout` is set, and the FSM proceeds as from STORE. `timeout` clears when the next `start` is accepted.
- Decision order, applied in DECIDE:
  - If blue > red and blue > green (strict), color = yellow.
  - Otherwise, color = the channel with the minimum value. Ties resolve with priority red, then green, then blue.
  - All three channels equal gives red.
- `start` while busy is ignored; nothing is queued.

## Timing
- Reset values: state IDLE, `color_select` 01, `busy` 0, `done` 0, `color` 00, `timeout` 0, all period outputs 0.
- `start` high at edge t in IDLE: `busy` = 1 and `color_select` = 00 from t+1.
- A `freq_in` rising edge first sampled at clk edge k produces the `edge` pulse at k+2.
- The period register for a channel updates one cycle after the terminating `edge`.
- `done` is high for exactly one cycle. In that same cycle `busy` = 0, `color_select` = 01, and `color` is valid; `color` holds until the next DECIDE.
- A `start` asserted in the `done` cycle is accepted, since the FSM is in IDLE.
- Minimum run length ≈ 3·(SETTLE_CYCLES + 2^AVG_LOG2·P) + small constant, where P is the sensor period in clk cycles.
- `reset` mid-run returns every state and output to its reset value immediately; no `done` is produced.

## Test plan
- Default parameters, period 80/160/240 clk on red/green/blue → periods 10/20/30, `color` 11 (yellow), `done` one cycle, `timeout` 0.
- Periods 240/80/160 → 30/10/20, `color` 01 (green).
- All channels period 80 → 10/10/10, `color` 00 (red, tie priority).
- `freq_in` held low during the green channel, TIMEOUT_CYCLES = 4096 → `green_period` 255, `timeout` 1. Red and blue measured normally; result still produced.
- Period 4000 on red → 4000>>3 = 500, saturates to `red_period` 255. Pulse `start` again mid-run → ignored; exactly one `done` per accepted `start`.
- Assert `reset` during MEASURE of blue → next cycle `busy` 0, `color_select` 01, periods 0, no `done`. A subsequent `start` completes normally.
